// File: rtl/edge_pkg.sv
// Shared types and sizing for the edge bitmap packer: FSM states, pixel width,
// default frame size and the derived address / edge-count widths.
package edge_pkg;
  localparam int PIX_W      = 8;
  localparam int NPIX_DEF   = 65536;
  localparam int ADDR_W_DEF = $clog2(NPIX_DEF / 8);
  localparam int CNT_W      = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/edge_pack_writer_if.sv
// Pixel stream in, result SRAM write port and frame status out.
// The master side drives pixels; the slave side is the packer.
interface edge_pack_writer_if
  import edge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic [PIX_W-1:0]  thresh;
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [CNT_W-1:0]  edge_cnt;
  logic              busy;
  logic              done;

  modport master (
    output start, thresh, in_valid, in_pixel,
    input  wr_en, wr_addr, wr_data, edge_cnt, busy, done
  );

  modport slave (
    input  start, thresh, in_valid, in_pixel,
    output wr_en, wr_addr, wr_data, edge_cnt, busy, done
  );
endinterface

// File: rtl/edge_pack_writer_bit_packer8.sv
// Collects 8 serial bits MSB-first and emits a registered byte strobe
// one cycle after the 8th bit; the bit counter wraps with no bubble.
module bit_packer8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       byte_valid,
  output logic [7:0] byte_out
);
  logic [6:0] sr_reg;
  logic [2:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg     <= '0;
      cnt_reg    <= '0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (clr) begin
        sr_reg  <= '0;
        cnt_reg <= '0;
      end else if (bit_valid) begin
        sr_reg  <= {sr_reg[5:0], bit_in};
        cnt_reg <= cnt_reg + 3'd1;
        // The 7 stored bits plus the incoming one form the finished byte
        if (cnt_reg == 3'd7) begin
          byte_valid <= 1'b1;
          byte_out   <= {sr_reg, bit_in};
        end
      end
    end
  end
endmodule

// File: rtl/edge_pack_writer.sv
// Binarises the filtered pixel stream against a per-frame threshold, packs
// 8 edge bits per byte into the result SRAM and tracks the frame edge count.
module edge_pack_writer
  import edge_pkg::*;
#(
  parameter int NPIX   = NPIX_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  edge_pack_writer_if.slave bus
);
  localparam int              PC_W     = ADDR_W + 3;
  localparam logic [PC_W-1:0] LAST_PIX = PC_W'(NPIX - 1);

  state_t            state_reg, state_next;
  logic [PIX_W-1:0]  thr_reg;
  logic [PC_W-1:0]   pix_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              busy_reg, done_reg;
  logic              accept, bit_val, group_end;
  logic              byte_valid;
  logic [7:0]        byte_out;

  // start takes priority over a coincident pixel, which is dropped
  assign accept    = (state_reg == RUN) && bus.in_valid && !bus.start;
  assign bit_val   = bus.in_pixel > thr_reg;
  assign group_end = accept && (pix_cnt_reg[2:0] == 3'd7);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (bus.start) state_next = RUN;
      RUN: begin
        if (bus.start)
          state_next = RUN;
        else if (accept && (pix_cnt_reg == LAST_PIX))
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
    end
  end

  // The byte index is the upper part of the pixel counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_reg      <= '0;
      pix_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      wr_addr_reg  <= '0;
    end else if (bus.start) begin
      thr_reg      <= bus.thresh;
      pix_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
    end else if (accept) begin
      pix_cnt_reg  <= pix_cnt_reg + PC_W'(1);
      edge_cnt_reg <= edge_cnt_reg + CNT_W'(bit_val);
      if (group_end)
        wr_addr_reg <= pix_cnt_reg[PC_W-1:3];
    end
  end

  bit_packer8 u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.start),
    .bit_valid  (accept),
    .bit_in     (bit_val),
    .byte_valid (byte_valid),
    .byte_out   (byte_out)
  );

  assign bus.wr_en    = byte_valid;
  assign bus.wr_data  = byte_out;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.edge_cnt = edge_cnt_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_edge_pack_writer.sv
// Self-checking bench for edge_pack_writer: table-driven basic pack, directed
// corner sequences and random traffic, all checked against a frame-level model.
module tb_edge_pack_writer;
  import edge_pkg::*;

  localparam int NPIX = 65536;
  localparam int AW   = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_pack_writer_if #(.ADDR_W(AW)) bus();

  edge_pack_writer #(.NPIX(NPIX), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int writes_seen = 0;

  // Model: a frame is a list of accepted bits; every full group of 8 is a write.
  int m_mode;           // 0 idle, 1 run, 2 done
  int m_thr;
  bit m_grp[$];
  int m_npix;
  int m_ecnt;
  bit m_wr_en;
  int m_addr;
  int m_data;

  typedef struct {
    bit         s;
    logic [7:0] th;
    bit         v;
    logic [7:0] px;
    bit         e_wr;
    logic [7:0] e_data;
    int         e_cnt;
    bit         e_busy;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] basic_px[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_thr = 0; m_grp.delete(); m_npix = 0;
    m_ecnt = 0; m_wr_en = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step(input bit s, input int th, input bit v, input int px);
    bit b;
    m_wr_en = 0;
    if (s) begin
      m_mode = 1; m_thr = th; m_grp.delete(); m_npix = 0; m_ecnt = 0;
    end else if (m_mode == 1 && v) begin
      b = (px > m_thr);
      m_grp.push_back(b);
      m_ecnt += int'(b);
      m_npix++;
      if (m_grp.size() == 8) begin
        m_wr_en = 1;
        m_data = 0;
        for (int i = 0; i < 8; i++) m_data[7-i] = m_grp[i];
        m_addr = m_npix / 8 - 1;
        m_grp.delete();
      end
      if (m_npix == NPIX) m_mode = 2;
    end
  endtask

  task automatic check_model();
    if (bus.wr_en === 1'b1) begin
      writes_seen++;
      $display("write addr=0x%04h data=0x%02h edge_cnt=%0d", bus.wr_addr, bus.wr_data, bus.edge_cnt);
    end
    chk("wr_en",    32'(bus.wr_en),    32'(m_wr_en));
    chk("wr_addr",  32'(bus.wr_addr),  32'(m_addr));
    chk("wr_data",  32'(bus.wr_data),  32'(m_data));
    chk("edge_cnt", 32'(bus.edge_cnt), 32'(m_ecnt));
    chk("busy",     32'(bus.busy),     32'(m_mode == 1));
    chk("done",     32'(bus.done),     32'(m_mode == 2));
  endtask

  // Called at a falling edge: drive, clock, then check at the next falling edge.
  task automatic step(input bit s, input logic [7:0] th, input bit v, input logic [7:0] px);
    bus.start = s; bus.thresh = th; bus.in_valid = v; bus.in_pixel = px;
    @(posedge clk);
    model_step(s, int'(th), v, int'(px));
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    chk({tag, "_edge_cnt"}, 32'(bus.edge_cnt), 32'd0);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
  endtask

  initial begin
    basic_px = '{8'hFF, 8'h00, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00, 8'hC0};
    // Row 0 starts the frame; rows 1..8 are pixels; row 9 is an idle cycle.
    tbl[0] = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h81, 1'b0, 8'h00, 2, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00, 2, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 2, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 2, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 2, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 8'hC0, 1'b1, 8'hA1, 3, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA1, 3, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.thresh = 8'h00; bus.in_valid = 1'b0; bus.in_pixel = 8'h00;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic pack, table-driven
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].th, tbl[i].v, tbl[i].px);
      chk("tbl_wr_en",    32'(bus.wr_en),    32'(tbl[i].e_wr));
      if (tbl[i].e_wr || i == 9) chk("tbl_wr_data", 32'(bus.wr_data), 32'(tbl[i].e_data));
      if (tbl[i].e_wr) chk("tbl_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("tbl_edge_cnt", 32'(bus.edge_cnt), 32'(tbl[i].e_cnt));
      chk("tbl_busy",     32'(bus.busy),     32'(tbl[i].e_busy));
    end

    // Gapped input: 0-3 idle cycles before each pixel
    step(1'b1, 8'h80, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 8'h00, 1'b0, 8'($urandom));
        chk("gap_no_write", 32'(bus.wr_en), 32'd0);
      end
      step(1'b0, 8'h00, 1'b1, basic_px[i]);
    end
    chk("gap_wr_en",   32'(bus.wr_en),   32'd1);
    chk("gap_wr_data", 32'(bus.wr_data), 32'hA1);
    chk("gap_wr_addr", 32'(bus.wr_addr), 32'd0);

    // Abort: 5 pixels, then start with a coincident pixel
    step(1'b1, 8'h80, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h80, 1'b1, 8'hFF);
    step(1'b1, 8'h80, 1'b1, 8'hFF);
    chk("abort_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("abort_busy",     32'(bus.busy),     32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h80, 1'b1, 8'hFF);
      if (i < 7) chk("abort_no_write", 32'(bus.wr_en), 32'd0);
    end
    chk("abort_wr_en",   32'(bus.wr_en),   32'd1);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_wr_data", 32'(bus.wr_data), 32'hFF);

    // Threshold latch: thresh input moves above the pixels mid-frame
    step(1'b1, 8'h10, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i < 3) ? 8'h10 : 8'hF0, 1'b1, 8'h20);
      if (i % 8 == 7) chk("thr_wr_data", 32'(bus.wr_data), 32'hFF);
    end
    chk("thr_edge_cnt", 32'(bus.edge_cnt), 32'd16);

    // Reset mid-frame after three bytes
    step(1'b1, 8'h40, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) step(1'b0, 8'h40, 1'b1, 8'($urandom));
    chk("pre_rst_wr_addr", 32'(bus.wr_addr), 32'd2);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 8'hFF);
    chk("idle_ignore_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("idle_ignore_wr_en",    32'(bus.wr_en),    32'd0);

    // Random traffic with occasional restarts
    step(1'b1, 8'($urandom), 1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), 8'($urandom),
           ($urandom_range(0, 9) < 7), 8'($urandom));
    end

    // Full frame, back-to-back, every pixel an edge
    step(1'b1, 8'h00, 1'b0, 8'h00);
    writes_seen = 0;
    for (int i = 0; i < NPIX; i++) step(1'b0, 8'h5A, 1'b1, 8'hFF);
    chk("full_writes",   32'(writes_seen),  32'(NPIX / 8));
    chk("full_wr_en",    32'(bus.wr_en),    32'd1);
    chk("full_wr_addr",  32'(bus.wr_addr),  32'h1FFF);
    chk("full_wr_data",  32'(bus.wr_data),  32'hFF);
    chk("full_edge_cnt", 32'(bus.edge_cnt), 32'd65536);
    chk("full_done",     32'(bus.done),     32'd1);
    chk("full_busy",     32'(bus.busy),     32'd0);
    step(1'b0, 8'h00, 1'b1, 8'hFF);
    chk("post_done_wr_en",    32'(bus.wr_en),    32'd0);
    chk("post_done_edge_cnt", 32'(bus.edge_cnt), 32'd65536);
    chk("post_done_done",     32'(bus.done),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/edge_pack_writer.md
# edge_pack_writer

Downstream stage of the edge-detect filter: consumes the filter's `out_pixel`/`out_valid` stream, binarises each pixel against a per-frame threshold, and packs 8 edge bits per byte, MSB-first. Each packed byte is written to an 8-bit result SRAM, with a running edge count. Frame boundaries come from a `start` pulse and a pixel counter. The finished bitmap is read back by the BMP dump logic.

## Interface
- `NPIX`, default 65536: pixels per frame; must be a multiple of 8 and ≤ 8·2^`ADDR_W`.
- `ADDR_W`, default 13: result SRAM byte-address width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: begin, or restart, a frame.
- `thresh`  in  8  binarisation threshold, unsigned; sampled on `start`.
- `in_valid`  in  1  pixel strobe, driven from filter `out_valid`; no backpressure.
- `in_pixel`  in  8  filter magnitude, unsigned, driven from filter `out_pixel`.
- `wr_en`  out  1  result SRAM write strobe, one cycle per byte.
- `wr_addr`  out  `ADDR_W`  byte index within the frame.
- `wr_data`  out  8  packed edge bits; the first pixel of the group is bit 7.
- `edge_cnt`  out  17  number of 1-bits in the frame so far (0..65536).
- `busy`  out  1  high in state RUN.
- `done`  out  1  high in state DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN: accepting pixels.
  - DONE: frame complete, holds results.
- IDLE/DONE → RUN on `start`. On that cycle:
  - `thr_q` ← `thresh`.
  - Pixel counter, bit counter, shift register, byte address and `edge_cnt` all clear.
- RUN, `in_valid`=1:
  - bit = (`in_pixel` > `thr_q`), strict compare.
  - Shift the bit into `sr[7:0]` from the LSB side, so the first pixel ends up in bit 7.
  - `edge_cnt` += bit.
  - Bit counter and pixel counter each increment by 1.
- When the 8th bit of a group is accepted:
  - Next cycle: `wr_en`=1, `wr_data` = the completed byte, `wr_addr` = current byte index.
  - Byte index then increments.
  - Bit counter wraps 7→0 with no bubble; a pixel in the same cycle as the write strobe is accepted normally.
- When the pixel counter reaches `NPIX`−1 and that pixel is accepted, RUN → DONE. The final write strobe occurs in the first DONE cycle.
- In IDLE/DONE, `in_valid` is ignored; `edge_cnt` and the last `wr_addr` hold.
- `start` in RUN aborts the frame:
  - The partial byte is discarded and no write is issued for it.
  - Re-initialises exactly as above and stays in RUN.
  - A pending write strobe from the previous cycle still completes.
- `start` and `in_valid` in the same cycle: `start` wins and the pixel is dropped.
- `thresh` changes mid-frame have no effect.
- `rst` mid-frame: immediate return to IDLE; all outputs go to their reset values; no further writes.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0x00, `edge_cnt`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Latency from the 8th pixel's `in_valid` edge to `wr_en` is 1 cycle.
- `edge_cnt` reflects a pixel 1 cycle after its acceptance.
- `busy` rises 1 cycle after `start`.
- `done` rises 1 cycle after the final pixel, concurrent with the last `wr_en`.
- Sustains `in_valid` every cycle: NPIX pixels → NPIX/8 writes, last `wr_addr` = NPIX/8−1 (0x1FFF at default).
- Gaps in `in_valid` stall packing without losing state.

## Structure
- Shared package `edge_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `PIX_W`=8;
  - the default `NPIX`;
  - the derived `ADDR_W` and `CNT_W`=17.
- One natural sub-module, `bit_packer8`:
  - contains the shift register, 3-bit counter and byte-ready strobe;
  - inputs: `clk`, `rst`, `clr`, `bit_valid`, `bit_in`;
  - outputs: `byte_valid`, `byte_out`.
- The FSM, counters, compare and SRAM port stay in the top.

## Test plan
- **Basic pack:** `start` with `thresh`=0x80; pixels 0xFF,0x00,0x81,0x80,0x00,0x00,0x00,0xC0 → one write, `wr_addr`=0, `wr_data`=0xA1, `edge_cnt`=3.
- **Full frame:** `NPIX`=65536, back-to-back valid, all pixels 0xFF, `thresh`=0 → 8192 writes of 0xFF at addresses 0..0x1FFF; `edge_cnt`=65536; `done`=1 in the cycle of the last write; `busy`=0.
- **Gapped input:** same 8 pixels as basic pack, with 0–3 idle cycles between them → identical write, arriving 1 cycle after the 8th valid.
- **Abort:** 5 pixels, then `start` with a coincident `in_valid` → no write; `edge_cnt`=0; the next 8 pixels produce a write at `wr_addr`=0.
- **Threshold latch:** `thresh` changed from 0x10 to 0xF0 mid-frame → all pixels 0x20 still yield 0xFF bytes.
- **Reset mid-frame:** `rst` after byte 3 → all outputs at reset values; `in_valid` ignored until `start`.
